// File: rtl/quad_pkg.sv
// Shared types and defaults for the quadrature decoder.
// Optional glitch filter is enabled by defining QUAD_GLITCH_FILTER_EN.
package quad_pkg;

   localparam int POS_W_DEF    = 8;
   localparam int FILT_CYC_DEF = 3;
   localparam int SYNC_STAGES  = 2;
   localparam int FILT_CNT_W   = 4;

   // {A,B}; up sequence is 00 -> 10 -> 11 -> 01 -> 00
   typedef enum logic [1:0] {
      PH_00 = 2'b00,
      PH_01 = 2'b01,
      PH_10 = 2'b10,
      PH_11 = 2'b11
   } phase_t;

   function automatic phase_t next_up(input phase_t p);
      case (p)
         PH_00:   return PH_10;
         PH_10:   return PH_11;
         PH_11:   return PH_01;
         default: return PH_00;
      endcase
   endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Two-flop synchronizer for one encoder phase, with an optional stability
// filter when QUAD_GLITCH_FILTER_EN is defined.
module quad_sync_filter
   import quad_pkg::*;
`ifdef QUAD_GLITCH_FILTER_EN
#(
   parameter int FILT_CYC = FILT_CYC_DEF
)
`endif
(
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
   end

`ifdef QUAD_GLITCH_FILTER_EN
   logic                  filt_q;
   logic [FILT_CNT_W-1:0] cnt;
   logic                  s;

   assign s = sync_q[SYNC_STAGES-1];

   // Accept a new level only once it has been sampled FILT_CYC times in a row;
   // any return to the accepted level restarts the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt_q <= 1'b0;
         cnt    <= '0;
      end else if (s == filt_q) begin
         cnt    <= '0;
      end else if (cnt == FILT_CNT_W'(FILT_CYC - 1)) begin
         filt_q <= s;
         cnt    <= '0;
      end else begin
         cnt    <= cnt + FILT_CNT_W'(1);
      end
   end

   assign dout = filt_q;
`else
   assign dout = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes A/B, decodes up/down/illegal transitions,
// keeps a wrapping position count. Glitch filter via QUAD_GLITCH_FILTER_EN.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int POS_W    = POS_W_DEF,
   parameter int FILT_CYC = FILT_CYC_DEF
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             a,
   input  logic             b,
   input  logic             clr,
   output logic             step,
   output logic             dir,
   output logic [POS_W-1:0] pos,
   output logic             err,
   output logic             err_sticky
);

`ifdef QUAD_GLITCH_FILTER_EN
   localparam bit FILT_EN = 1'b1;
`else
   localparam bit FILT_EN = 1'b0;
`endif

   // Synchronized phases are only meaningful once the sync (and filter)
   // pipeline has refilled after reset; until then prev just tracks cur.
   localparam int WARM = SYNC_STAGES + 1 + (FILT_EN ? FILT_CYC : 0);

   logic [1:0]      raw;
   logic [1:0]      syncd;
   phase_t          cur;
   phase_t          prev;
   logic [WARM-1:0] init_pipe;
   logic            init;
   logic            up_ev;
   logic            dn_ev;
   logic            bad_ev;

   assign raw = {a, b};

   for (genvar g = 0; g < 2; g++) begin : g_ph
`ifdef QUAD_GLITCH_FILTER_EN
      quad_sync_filter #(.FILT_CYC(FILT_CYC)) u_sf (
`else
      quad_sync_filter u_sf (
`endif
         .clk   (clk),
         .reset (reset),
         .din   (raw[g]),
         .dout  (syncd[g])
      );
   end

   assign cur    = phase_t'(syncd);
   assign init   = init_pipe[0];
   assign up_ev  = !init && (cur == next_up(prev));
   assign dn_ev  = !init && (prev == next_up(cur));
   assign bad_ev = !init && ((cur ^ prev) == 2'b11);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         init_pipe  <= '1;
         prev       <= PH_00;
         step       <= 1'b0;
         dir        <= 1'b0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
         pos        <= '0;
      end else begin
         init_pipe <= init_pipe >> 1;
         prev      <= cur;
         step      <= up_ev | dn_ev;
         err       <= bad_ev;
         if (up_ev)      dir <= 1'b1;
         else if (dn_ev) dir <= 1'b0;
         // clr wins over a coincident edge; the edge is still reported
         if (clr)        pos <= '0;
         else if (up_ev) pos <= pos + POS_W'(1);
         else if (dn_ev) pos <= pos - POS_W'(1);
         if (clr)         err_sticky <= 1'b0;
         else if (bad_ev) err_sticky <= 1'b1;
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder (default POS_W=8, FILT_CYC=3).
module tb_quad_decoder;

`ifdef QUAD_GLITCH_FILTER_EN
   localparam int FILT = 3;
`else
   localparam int FILT = 0;
`endif
   localparam int LAT  = 3 + FILT;   // negedges from drive to visible outputs
   localparam int WARM = 3 + FILT;
   localparam int S    = (FILT == 0) ? 1 : FILT;

   logic       clk = 1'b0;
   logic       reset, a, b, clr;
   logic       step, dir, err, err_sticky;
   logic [7:0] pos;
   int         checks = 0;
   int         failures = 0;

   quad_decoder #(.POS_W(8), .FILT_CYC(3)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .clr(clr),
      .step(step), .dir(dir), .pos(pos), .err(err), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b0; a = 1'b0; b = 1'b0; clr = 1'b0;
      tick(3);
      checks++; if ({step, dir, err, err_sticky} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {step, dir, err, err_sticky}); end
      checks++; if (pos !== 8'h00) begin failures++; $display("FAIL reset_pos got=%0h exp=0", pos); end
      reset = 1'b1;
      tick(WARM + 3);
      checks++; if ({step, err, pos} !== 10'd0) begin failures++; $display("FAIL post_reset got=%b exp=0", {step, err, pos}); end
   endtask

   task automatic test_up;
      logic [1:0] seq [4];
      seq = '{2'b10, 2'b11, 2'b01, 2'b00};
      for (int k = 0; k < 4; k++) begin
         {a, b} = seq[k];
         tick(LAT - 1);
         checks++; if (step !== 1'b0) begin failures++; $display("FAIL up_early%0d got=%b exp=0", k, step); end
         tick(1);
         checks++; if ({step, dir} !== 2'b11) begin failures++; $display("FAIL up_step%0d got=%b exp=11", k, {step, dir}); end
         checks++; if (pos !== 8'(k + 1)) begin failures++; $display("FAIL up_pos%0d got=%0h exp=%0h", k, pos, k + 1); end
         tick(1);
         checks++; if (step !== 1'b0) begin failures++; $display("FAIL up_pulse%0d got=%b exp=0", k, step); end
         tick(8 - LAT - 1);
      end
      checks++; if ({pos, err_sticky} !== {8'h04, 1'b0}) begin failures++; $display("FAIL up_final got=%0h/%b exp=4/0", pos, err_sticky); end
   endtask

   task automatic test_wrap;
      clr = 1'b1; tick(1); clr = 1'b0;
      checks++; if (pos !== 8'h00) begin failures++; $display("FAIL clr_pos got=%0h exp=0", pos); end
      b = 1'b1;                       // 00 -> 01 : down
      tick(LAT);
      checks++; if ({step, dir} !== 2'b10) begin failures++; $display("FAIL down_step got=%b exp=10", {step, dir}); end
      checks++; if (pos !== 8'hFF) begin failures++; $display("FAIL down_wrap got=%0h exp=ff", pos); end
      tick(5);
      checks++; if ({step, dir} !== 2'b00) begin failures++; $display("FAIL dir_hold got=%b exp=00", {step, dir}); end
      b = 1'b0;                       // 01 -> 00 : up
      tick(LAT);
      checks++; if ({step, dir, pos} !== {2'b11, 8'h00}) begin failures++; $display("FAIL up_wrap got=%b/%0h exp=11/0", {step, dir}, pos); end
      tick(4);
   endtask

   task automatic test_illegal;
      a = 1'b1; b = 1'b1;             // 00 -> 11 : illegal
      tick(LAT);
      checks++; if ({err, err_sticky, step, dir} !== 4'b1101) begin failures++; $display("FAIL illegal got=%b exp=1101", {err, err_sticky, step, dir}); end
      checks++; if (pos !== 8'h00) begin failures++; $display("FAIL illegal_pos got=%0h exp=0", pos); end
      tick(1);
      checks++; if ({err, err_sticky} !== 2'b01) begin failures++; $display("FAIL err_pulse got=%b exp=01", {err, err_sticky}); end
      tick(3);
      a = 1'b0;                       // 11 -> 01 : up
      tick(LAT);
      checks++; if ({step, dir, err, pos} !== {3'b110, 8'h01}) begin failures++; $display("FAIL after_err got=%b/%0h exp=110/1", {step, dir, err}, pos); end
      tick(4);
   endtask

   task automatic test_back_to_back;
      logic [1:0] seq [3];
      logic       exp_step;
      logic [7:0] exp_pos;
      seq = '{2'b00, 2'b10, 2'b11};
      exp_pos = 8'h01;
      for (int t = 0; t < LAT + 3 * S + 1; t++) begin
         if ((t % S) == 0 && (t / S) < 3) {a, b} = seq[t / S];
         tick(1);
         exp_step = ((t + 1) >= LAT) && (((t + 1 - LAT) % S) == 0) && (((t + 1 - LAT) / S) < 3);
         if (exp_step) exp_pos = exp_pos + 8'h01;
         checks++; if ({step, pos} !== {exp_step, exp_pos}) begin failures++; $display("FAIL b2b_t%0d got=%b/%0h exp=%b/%0h", t + 1, step, pos, exp_step, exp_pos); end
      end
      tick(4);
   endtask

   task automatic test_clr_step;
      a = 1'b0;                       // 11 -> 01 : up, with clr on the edge
      tick(LAT - 1);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      checks++; if ({step, dir} !== 2'b11) begin failures++; $display("FAIL clr_step got=%b exp=11", {step, dir}); end
      checks++; if ({pos, err_sticky} !== 9'd0) begin failures++; $display("FAIL clr_prio got=%0h/%b exp=0/0", pos, err_sticky); end
      tick(4);
   endtask

   task automatic test_reset_hold;
      int bad;
      reset = 1'b0; a = 1'b1; b = 1'b1;
      tick(3);
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < WARM + 8; i++) begin
         tick(1);
         if (step !== 1'b0 || err !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL reset_hold_events got=%0d exp=0", bad); end
      a = 1'b0;                       // 11 -> 01 : up
      tick(LAT);
      checks++; if ({step, dir, err, pos} !== {3'b110, 8'h01}) begin failures++; $display("FAIL reset_hold_step got=%b/%0h exp=110/1", {step, dir, err}, pos); end
      tick(4);
   endtask

`ifdef QUAD_GLITCH_FILTER_EN
   task automatic test_glitch;
      int seen;
      a = 1'b1; tick(2); a = 1'b0;    // 2-cycle pulse, must be ignored
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (step !== 1'b0 || err !== 1'b0) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL glitch got=%0d exp=0", seen); end
      a = 1'b1;                       // 01 -> 11 : down, held
      tick(LAT - 1);
      checks++; if (step !== 1'b0) begin failures++; $display("FAIL filt_early got=%b exp=0", step); end
      tick(1);
      checks++; if ({step, dir, pos} !== {2'b10, 8'h00}) begin failures++; $display("FAIL filt_step got=%b/%0h exp=10/0", {step, dir}, pos); end
      tick(4);
   endtask
`endif

   initial begin
      test_reset;
      test_up;
      test_wrap;
      test_illegal;
      test_back_to_back;
      test_clr_step;
      test_reset_hold;
`ifdef QUAD_GLITCH_FILTER_EN
      test_glitch;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The block SHALL have parameter POS_W, default 8, giving the position counter width in bits.
REQ-002 The block SHALL have parameter FILT_CYC, default 3, giving the glitch-filter stability length in clk cycles (legal range 1..15).
REQ-003 clk  input  1  rising-edge clock for all sequential logic.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 a  input  1  encoder phase A, asynchronous to clk.
REQ-006 b  input  1  encoder phase B, asynchronous to clk.
REQ-007 clr  input  1  synchronous clear of pos and err_sticky.
REQ-008 step  output  1  one-cycle pulse per valid quadrature edge.
REQ-009 dir  output  1  direction of the last valid edge (1 = up, 0 = down).
REQ-010 pos  output  POS_W  signed-agnostic up/down position count.
REQ-011 err  output  1  one-cycle pulse on an illegal (double-bit) phase change.
REQ-012 err_sticky  output  1  latched error flag, held until clr or reset.

Function
REQ-013 a and b SHALL each pass through a 2-flop synchronizer before any other use.
REQ-014 Phase state SHALL be {A,B}; the up sequence SHALL be 00->10->11->01->00 and the down sequence its reverse.
REQ-015 On an up transition: step=1 and dir=1 for one cycle; pos SHALL increment by 1 in the same cycle.
REQ-016 On a down transition: step=1 and dir=0 for one cycle; pos SHALL decrement by 1 in the same cycle.
REQ-017 pos SHALL wrap modulo 2^POS_W: all-ones +1 -> 0, and 0 -1 -> all-ones.
REQ-018 dir SHALL hold its value between valid edges.
REQ-019 An A and B change in the same observed sample SHALL give err=1 for one cycle and set err_sticky, with no step, no pos change and dir unchanged.
REQ-020 After any observed change, including an illegal one, the previous-state register SHALL take the new state.
REQ-021 Latency without the filter: an input change captured at rising edge N SHALL produce step/err and the updated pos after edge N+2.
REQ-022 clr SHALL take priority over a simultaneous edge: pos=0 and err_sticky=0; step/dir/err for that edge SHALL still be reported.
REQ-023 In the first cycle after reset release, the previous-state register SHALL load the current synchronized state with no step or err, so a nonzero input level out of reset is not an event.

Reset
REQ-024 While reset=0, the block SHALL force: synchronizers=0, previous state=0, pos=0, dir=0, step=0, err=0, err_sticky=0, filter counter=0, init flag set.
REQ-025 Reset asserted mid-sequence SHALL discard any in-flight filter count; no event SHALL be emitted on reset release.

Configuration
REQ-026 With macro QUAD_GLITCH_FILTER_EN defined, each synchronized phase SHALL be accepted only after FILT_CYC consecutive identical samples, adding exactly FILT_CYC cycles to the REQ-021 latency; pulses shorter than FILT_CYC cycles SHALL be ignored.
REQ-027 Without QUAD_GLITCH_FILTER_EN, the synchronizer outputs SHALL feed the decoder directly, and FILT_CYC SHALL be unused.

Structure
REQ-028 Shared package quad_pkg SHALL hold the 2-bit phase-state typedef, the named constants for 00/10/11/01, and the default POS_W and FILT_CYC values.
REQ-029 The synchronizer plus optional filter SHALL be one sub-module, quad_sync_filter, instantiated once per phase.
REQ-030 Transition decode, pos counter, and the error logic SHALL reside in quad_decoder.

Verification
REQ-031 Reset, then four up steps ({A,B} = 10, 11, 01, 00, each held 8 cycles) -> four step pulses, dir=1, pos=4, err_sticky=0.
REQ-032 pos=0, one down step (00->01) -> step=1, dir=0, pos=all-ones (8'hFF); then one up step -> pos=8'h00.
REQ-033 Drive 00->11 in one cycle -> err=1 for one cycle, err_sticky=1, pos unchanged; a following valid step counts normally.
REQ-034 Hold a=b=1 through reset release -> no step/err; the next change 11->01 -> step, dir=1, pos=1.
REQ-035 With QUAD_GLITCH_FILTER_EN, FILT_CYC=3: a 2-cycle pulse on A -> no step; a 3-cycle-stable change -> step exactly FILT_CYC cycles later than in an unfiltered build.
REQ-036 Assert clr in the same cycle as a step -> pos=0, err_sticky=0, step still pulses.
